// File: rtl/qpsk_rx_pkg.sv
// Shared types and constants for the QPSK frame receiver.
package qpsk_rx_pkg;

  // Receiver lock state: searching for header, inside header run, decoding data.
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    HEAD = 2'd1,
    DATA = 2'd2
  } rx_state_t;

  // Sliced bit values of a header symbol (I positive, Q negative).
  localparam logic HDR_IBIT = 1'b1;
  localparam logic HDR_QBIT = 1'b0;

  // Each symbol carries 2 bits, so four symbols make one byte.
  localparam int SYM_PER_BYTE = 4;

endpackage

// File: rtl/qpsk_slicer.sv
// Combinational hard slicer: sign decisions, header detect and weak detect.
module qpsk_slicer
  import qpsk_rx_pkg::*;
#(
  parameter int WEAK_TH = 2
) (
  input  logic [3:0] i_i,
  input  logic [3:0] i_q,
  output logic       o_ibit,
  output logic       o_qbit,
  output logic       o_is_header,
  output logic       o_is_weak
);

  logic [4:0] w_i_ext;
  logic [4:0] w_q_ext;
  logic [4:0] w_i_abs;
  logic [4:0] w_q_abs;

  // Magnitudes are taken in 5 bits so that -8 becomes +8 rather than wrapping.
  always_comb begin
    w_i_ext     = {i_i[3], i_i};
    w_q_ext     = {i_q[3], i_q};
    w_i_abs     = i_i[3] ? (5'd0 - w_i_ext) : w_i_ext;
    w_q_abs     = i_q[3] ? (5'd0 - w_q_ext) : w_q_ext;
    o_ibit      = ~i_i[3];
    o_qbit      = ~i_q[3];
    o_is_header = (o_ibit == HDR_IBIT) && (o_qbit == HDR_QBIT);
    o_is_weak   = (w_i_abs < 5'(WEAK_TH)) || (w_q_abs < 5'(WEAK_TH));
  end

endmodule

// File: rtl/qpsk_frame_rx.sv
// QPSK frame receiver: header lock, byte packing and per-frame weak-symbol count.
// Valid/ready contract: there is no ready; byte_valid is a one-cycle pulse and the
// consumer must take byte_out in that cycle. rx_en=0 freezes all state.
module qpsk_frame_rx
  import qpsk_rx_pkg::*;
#(
  parameter int HEAD_LEN    = 5,
  parameter int PRE_MIN     = 3,
  parameter int FRAME_BYTES = 8,
  parameter int WEAK_TH     = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   rx_en,
  input  logic [3:0]                             I_in,
  input  logic [3:0]                             Q_in,
  output logic [7:0]                             byte_out,
  output logic                                   byte_valid,
  output logic                                   frame_done,
  output logic [$clog2(FRAME_BYTES*4+1)-1:0]     weak_count,
  output logic                                   locked
);

  localparam int WEAK_W = $clog2(FRAME_BYTES * SYM_PER_BYTE + 1);
  localparam int RUN_W  = $clog2(HEAD_LEN + 1);
  localparam int SYM_W  = $clog2(SYM_PER_BYTE);
  localparam int BYTE_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

  localparam logic [RUN_W-1:0]  PRE_MIN_C   = RUN_W'(PRE_MIN);
  localparam logic [RUN_W-1:0]  HEAD_LEN_C  = RUN_W'(HEAD_LEN);
  localparam logic [SYM_W-1:0]  SYM_LAST_C  = SYM_W'(SYM_PER_BYTE - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST_C = BYTE_W'(FRAME_BYTES - 1);

  rx_state_t         r_state;
  rx_state_t         w_state_nxt;
  logic [RUN_W-1:0]  r_run;
  logic [RUN_W-1:0]  w_run_nxt;
  logic [RUN_W-1:0]  w_run_inc;
  logic [SYM_W-1:0]  r_sym;
  logic [BYTE_W-1:0] r_byte;
  logic [5:0]        r_shift;
  logic [7:0]        w_shift_nxt;
  logic [WEAK_W-1:0] r_acc;
  logic [WEAK_W-1:0] w_acc_nxt;
  logic [7:0]        r_byte_out;
  logic              r_byte_valid;
  logic              r_frame_done;
  logic [WEAK_W-1:0] r_weak_count;

  logic w_ibit;
  logic w_qbit;
  logic w_is_hdr;
  logic w_is_weak;
  logic w_take_data;
  logic w_byte_end;
  logic w_frame_end;

  qpsk_slicer #(
    .WEAK_TH(WEAK_TH)
  ) u_slicer (
    .i_i        (I_in),
    .i_q        (Q_in),
    .o_ibit     (w_ibit),
    .o_qbit     (w_qbit),
    .o_is_header(w_is_hdr),
    .o_is_weak  (w_is_weak)
  );

  assign w_run_inc   = r_run + RUN_W'(1);
  assign w_byte_end  = (r_sym == SYM_LAST_C);
  assign w_frame_end = (r_byte == BYTE_LAST_C);
  assign w_shift_nxt = {r_shift, w_ibit, w_qbit};
  assign w_acc_nxt   = r_acc + WEAK_W'(w_is_weak);

  // Next-state logic; w_take_data marks a sample that is decoded as a data symbol.
  // A non-header symbol that ends a short header is itself data symbol 0.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_take_data = 1'b0;
    if (rx_en) begin
      case (r_state)
        HUNT: begin
          if (w_is_hdr) begin
            w_run_nxt = w_run_inc;
            if (w_run_inc == PRE_MIN_C) w_state_nxt = HEAD;
          end else begin
            w_run_nxt = '0;
          end
        end
        HEAD: begin
          if (w_is_hdr) begin
            if (w_run_inc == HEAD_LEN_C) begin
              w_state_nxt = DATA;
              w_run_nxt   = '0;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end else begin
            w_state_nxt = DATA;
            w_run_nxt   = '0;
            w_take_data = 1'b1;
          end
        end
        DATA: begin
          w_take_data = 1'b1;
          if (w_byte_end && w_frame_end) w_state_nxt = HUNT;
        end
        default: begin
          w_state_nxt = HUNT;
          w_run_nxt   = '0;
        end
      endcase
    end
  end

  // State register and header run counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HUNT;
      r_run   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
    end
  end

  // Data path: shift symbols into bytes, count weak symbols, emit byte/frame pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sym        <= '0;
      r_byte       <= '0;
      r_shift      <= '0;
      r_acc        <= '0;
      r_byte_out   <= '0;
      r_byte_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_weak_count <= '0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_take_data) begin
        r_shift <= w_shift_nxt[5:0];
        r_sym   <= r_sym + SYM_W'(1);
        r_acc   <= w_acc_nxt;
        if (w_byte_end) begin
          r_byte_out   <= w_shift_nxt;
          r_byte_valid <= 1'b1;
          if (w_frame_end) begin
            r_byte       <= '0;
            r_frame_done <= 1'b1;
            r_weak_count <= w_acc_nxt;
            r_acc        <= '0;
          end else begin
            r_byte <= r_byte + BYTE_W'(1);
          end
        end
      end
    end
  end

  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
  assign frame_done = r_frame_done;
  assign weak_count = r_weak_count;
  assign locked     = (r_state != HUNT);

endmodule

// File: tb/tb_qpsk_frame_rx.sv
// Directed bench for qpsk_frame_rx.
module tb_qpsk_frame_rx;
  import qpsk_rx_pkg::*;

  logic       clk;
  logic       reset;
  logic       rx_en;
  logic [3:0] I_in;
  logic [3:0] Q_in;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_done;
  logic [5:0] weak_count;
  logic       locked;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  qpsk_frame_rx dut (
    .clk       (clk),
    .reset     (reset),
    .rx_en     (rx_en),
    .I_in      (I_in),
    .Q_in      (Q_in),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .frame_done(frame_done),
    .weak_count(weak_count),
    .locked    (locked)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted sample; outputs are examined 1 time unit after the edge.
  task automatic send(input int i, input int q);
    I_in  = 4'(i);
    Q_in  = 4'(q);
    rx_en = 1'b1;
    @(posedge clk);
    #1;
    rx_en = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_hdr(input int n);
    for (int k = 0; k < n; k++) send(4, -4);
  endtask

  // Strong-symbol encoding of a byte, MSB pair first: bit1 -> I sign, bit0 -> Q sign.
  task automatic send_byte(input logic [7:0] b);
    logic [1:0] pr;
    for (int s = 0; s < 4; s++) begin
      pr = b[7-2*s -: 2];
      send(pr[1] ? 4 : -4, pr[0] ? 4 : -4);
    end
  endtask

  task automatic do_reset();
    rx_en = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    reset = 1'b0;
    rx_en = 1'b0;
    I_in  = '0;
    Q_in  = '0;
    @(posedge clk);
    #1;
    do_reset();
    idle(1);

    // Reset state
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_byte_valid", {7'd0, byte_valid}, 8'h00);
    chk("rst_frame_done", {7'd0, frame_done}, 8'h00);
    chk("rst_weak_count", {2'd0, weak_count}, 8'h00);
    chk("rst_locked", {7'd0, locked}, 8'h00);

    // T1: 5 header symbols, first byte 11 00 10 01 = 0xC9
    send_hdr(2);
    chk("t1_unlocked_at2", {7'd0, locked}, 8'h00);
    send_hdr(1);
    chk("t1_locked_at3", {7'd0, locked}, 8'h01);
    send_hdr(2);
    chk("t1_state_data", 8'(dut.r_state), 8'(DATA));
    send(4, 4);
    send(-4, -4);
    send(4, -4);
    chk("t1_no_valid_3sym", {7'd0, byte_valid}, 8'h00);
    send(-4, 4);
    chk("t1_valid", {7'd0, byte_valid}, 8'h01);
    chk("t1_byte", byte_out, 8'hC9);
    chk("t1_acc", {2'd0, dut.r_acc}, 8'h00);
    chk("t1_fd_early", {7'd0, frame_done}, 8'h00);
    for (int k = 1; k < 8; k++) begin
      v = 8'(8'h11 * k);
      send_byte(v);
      chk("t1_bv", {7'd0, byte_valid}, 8'h01);
      chk("t1_bo", byte_out, v);
      chk("t1_fd", {7'd0, frame_done}, (k == 7) ? 8'h01 : 8'h00);
    end
    chk("t1_locked_fall", {7'd0, locked}, 8'h00);
    idle(1);
    chk("t1_valid_pulse", {7'd0, byte_valid}, 8'h00);
    chk("t1_fd_pulse", {7'd0, frame_done}, 8'h00);
    chk("t1_byte_hold", byte_out, 8'h77);

    // T2: full frame of 0xF0 bytes
    send_hdr(5);
    for (int k = 0; k < 8; k++) begin
      send_byte(8'hF0);
      chk("t2_bv", {7'd0, byte_valid}, 8'h01);
      chk("t2_bo", byte_out, 8'hF0);
      chk("t2_fd", {7'd0, frame_done}, (k == 7) ? 8'h01 : 8'h00);
    end
    chk("t2_weak", {2'd0, weak_count}, 8'h00);
    chk("t2_locked", {7'd0, locked}, 8'h00);
    chk("t2_state_hunt", 8'(dut.r_state), 8'(HUNT));

    // T3: weak symbols; byte0 0xBF (2 weak), byte1 0x19 (1 weak, -8 and +/-2 strong)
    send_hdr(5);
    send(1, -1);
    send(0, 4);
    send(4, 4);
    send(4, 4);
    chk("t3_byte0", byte_out, 8'hBF);
    send(-8, -8);
    send(-2, 2);
    send(2, -2);
    send(-1, 4);
    chk("t3_byte1", byte_out, 8'h19);
    for (int k = 2; k < 8; k++) send_byte(8'h5A);
    chk("t3_fd", {7'd0, frame_done}, 8'h01);
    chk("t3_weak", {2'd0, weak_count}, 8'h03);

    // T4: run broken at 2, then data-like symbols must not lock
    send(4, -4);
    send(4, -4);
    send(-4, -4);
    send(4, -4);
    for (int k = 0; k < 4; k++) begin
      send(4, 4);
      chk("t4_no_valid", {7'd0, byte_valid}, 8'h00);
      chk("t4_unlocked", {7'd0, locked}, 8'h00);
    end
    chk("t4_weak_hold", {2'd0, weak_count}, 8'h03);
    send_hdr(3);
    chk("t4_relock", {7'd0, locked}, 8'h01);

    // T5: finish header, pause mid-byte, then reset mid-frame
    send_hdr(2);
    send(4, 4);
    send(4, 4);
    idle(3);
    chk("t5_pause_no_valid", {7'd0, byte_valid}, 8'h00);
    send(-4, -4);
    send(-4, 4);
    chk("t5_bv", {7'd0, byte_valid}, 8'h01);
    chk("t5_byte", byte_out, 8'hF1);
    send_byte(8'h3C);
    chk("t5_byte1", byte_out, 8'h3C);
    send_byte(8'h81);
    chk("t5_byte2", byte_out, 8'h81);
    send(4, 4);
    send(-4, 4);
    do_reset();
    chk("t5_rst_byte", byte_out, 8'h00);
    chk("t5_rst_bv", {7'd0, byte_valid}, 8'h00);
    chk("t5_rst_weak", {2'd0, weak_count}, 8'h00);
    chk("t5_rst_locked", {7'd0, locked}, 8'h00);
    chk("t5_rst_state", 8'(dut.r_state), 8'(HUNT));
    idle(2);
    chk("t5_no_fd", {7'd0, frame_done}, 8'h00);

    // T6: 7 header symbols; the last two decode as data 10,10 -> 0xAF
    send_hdr(7);
    chk("t6_no_valid_yet", {7'd0, byte_valid}, 8'h00);
    send(4, 4);
    send(4, 4);
    chk("t6_bv", {7'd0, byte_valid}, 8'h01);
    chk("t6_byte", byte_out, 8'hAF);
    for (int k = 1; k < 8; k++) send_byte(8'hE4);
    chk("t6_byte_last", byte_out, 8'hE4);
    chk("t6_fd", {7'd0, frame_done}, 8'h01);

    // T7: header cut short at 3; the breaking symbol is data symbol 0 -> 0x7F
    send_hdr(3);
    send(-4, 4);
    chk("t7_locked", {7'd0, locked}, 8'h01);
    send(4, 4);
    send(4, 4);
    send(4, 4);
    chk("t7_bv", {7'd0, byte_valid}, 8'h01);
    chk("t7_byte", byte_out, 8'h7F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
